ram_arbiter: RTL and testbench

Two-requester controller that shares one single-port RAM (synchronous write, asynchronous read, `DEPTH` x `WIDTH`) between two independent clients. Sits directly in front of the RAM instance and owns its `WE`/`A`/`WD` inputs. Performs at most one access per cycle, using round-robin arbitration and valid/ready handshakes. Read data is returned one cycle later on a per-requester registered response channel. Optionally zero-clears the whole array after reset.

---
 rtl/ram_arbiter.sv | 149 ++++++++++++++
 tb/tb_ram_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Round-robin arbiter sharing one single-port RAM (synchronous
//               write, asynchronous read) between two valid/ready requesters.
//               Read data is returned one cycle after the grant on a
//               per-requester registered response channel.
//               Optional macro RAM_ARB_INIT_EN adds an INIT state that
//               zero-clears the whole RAM after every reset.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic                     req0_we,
  input  logic [$clog2(DEPTH)-1:0] req0_addr,
  input  logic [WIDTH-1:0]         req0_wdata,
  output logic                     rsp0_valid,
  output logic [WIDTH-1:0]         rsp0_rdata,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic                     req1_we,
  input  logic [$clog2(DEPTH)-1:0] req1_addr,
  input  logic [WIDTH-1:0]         req1_wdata,
  output logic                     rsp1_valid,
  output logic [WIDTH-1:0]         rsp1_rdata,
  output logic                     WE,
  output logic [$clog2(DEPTH)-1:0] A,
  output logic [WIDTH-1:0]         WD,
  input  logic [WIDTH-1:0]         RD
);

  localparam int AW = $clog2(DEPTH);

  logic             ptr_q, ptr_d;
  logic             run_en;
  logic             gnt0, gnt1;
  logic             rsp0_valid_q, rsp1_valid_q;
  logic [WIDTH-1:0] rsp0_rdata_q, rsp1_rdata_q;

`ifdef RAM_ARB_INIT_EN
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] init_cnt_q, init_cnt_d;
  logic          init_act;

  // State register and clear-address counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Walk the clear address across the array once, then hand over to RUN
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + AW'(1);
      if (init_cnt_q == AW'(DEPTH - 1)) begin
        state_d = ST_RUN;
      end
    end
  end

  assign init_act = (state_q == ST_INIT);
  assign run_en   = (state_q == ST_RUN) && !rst;
`else
  // Arbitration is live as soon as reset is released; readies stay low in reset
  assign run_en = !rst;
`endif

  // Grant decision, pointer next-state and RAM port drive
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    ptr_d      = ptr_q;
    WE         = 1'b0;
    A          = '0;
    WD         = '0;
`ifdef RAM_ARB_INIT_EN
    if (init_act) begin
      WE = 1'b1;
      A  = init_cnt_q;
    end
`endif
    if (run_en) begin
      // Each ready depends only on the other side's valid and the pointer
      req0_ready = !req1_valid || (ptr_q == 1'b0);
      req1_ready = !req0_valid || (ptr_q == 1'b1);
      gnt0       = req0_valid && req0_ready;
      gnt1       = req1_valid && req1_ready;
      if (gnt0) begin
        WE    = req0_we;
        A     = req0_addr;
        WD    = req0_wdata;
        ptr_d = 1'b1;
      end else if (gnt1) begin
        WE    = req1_we;
        A     = req1_addr;
        WD    = req1_wdata;
        ptr_d = 1'b0;
      end
    end
  end

  // Priority pointer and registered read responses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q        <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      rsp0_valid_q <= gnt0 && !req0_we;
      rsp1_valid_q <= gnt1 && !req1_we;
      if (gnt0 && !req0_we) begin
        rsp0_rdata_q <= RD;
      end
      if (gnt1 && !req1_we) begin
        rsp1_rdata_q <= RD;
      end
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_rdata = rsp0_rdata_q;
  assign rsp1_rdata = rsp1_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Self-checking bench for ram_arbiter with a behavioural RAM and
//               a transaction-level reference model (memory array, pointer,
//               last response per requester). Honours RAM_ARB_INIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

  localparam int DEPTH = 8;
  localparam int WIDTH = 32;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req0_ready, req0_we;
  logic [AW-1:0]    req0_addr;
  logic [WIDTH-1:0] req0_wdata;
  logic             rsp0_valid;
  logic [WIDTH-1:0] rsp0_rdata;
  logic             req1_valid, req1_ready, req1_we;
  logic [AW-1:0]    req1_addr;
  logic [WIDTH-1:0] req1_wdata;
  logic             rsp1_valid;
  logic [WIDTH-1:0] rsp1_rdata;
  logic             WE;
  logic [AW-1:0]    A;
  logic [WIDTH-1:0] WD;
  logic [WIDTH-1:0] RD;

  // Physical RAM: synchronous write, asynchronous read
  logic [WIDTH-1:0] ram [DEPTH];

  // Reference model state
  logic [WIDTH-1:0] m_mem [DEPTH];
  int               m_ptr;
  logic [WIDTH-1:0] m_rd0, m_rd1;

  int n_checks = 0;
  int n_errors = 0;

  ram_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_we    (req1_we),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .WE         (WE),
    .A          (A),
    .WD         (WD),
    .RD         (RD)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (WE) ram[A] <= WD;
  end
  assign RD = ram[A];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set0(input logic v, input logic we, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
  endtask

  task automatic set1(input logic v, input logic we, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
  endtask

  // One arbitrated cycle: predict the winner from the round-robin rule,
  // check handshake and RAM drive mid-cycle, then check responses after the edge.
  task automatic cycle();
    int               g;
    logic             ev0, ev1;
    logic             gwe;
    logic [AW-1:0]    ga;
    logic [WIDTH-1:0] gd;
    @(negedge clk);
    if (req0_valid && req1_valid) g = m_ptr;
    else if (req0_valid)          g = 0;
    else if (req1_valid)          g = 1;
    else                          g = -1;
    check("ready0", req0_ready, (!req1_valid || m_ptr == 0));
    check("ready1", req1_ready, (!req0_valid || m_ptr == 1));
    ev0 = 1'b0;
    ev1 = 1'b0;
    if (g >= 0) begin
      gwe = (g == 0) ? req0_we    : req1_we;
      ga  = (g == 0) ? req0_addr  : req1_addr;
      gd  = (g == 0) ? req0_wdata : req1_wdata;
      check("ram_we", WE, gwe);
      check("ram_a",  A,  ga);
      check("ram_wd", WD, gd);
      if (gwe) begin
        m_mem[ga] = gd;
      end else if (g == 0) begin
        m_rd0 = m_mem[ga];
        ev0   = 1'b1;
      end else begin
        m_rd1 = m_mem[ga];
        ev1   = 1'b1;
      end
      m_ptr = 1 - g;
    end else begin
      check("idle_we", WE, 1'b0);
      check("idle_a",  A,  '0);
      check("idle_wd", WD, '0);
    end
    @(posedge clk);
    #1;
    check("rsp0_valid", rsp0_valid, ev0);
    check("rsp1_valid", rsp1_valid, ev1);
    check("rsp0_rdata", rsp0_rdata, m_rd0);
    check("rsp1_rdata", rsp1_rdata, m_rd1);
  endtask

`ifdef RAM_ARB_INIT_EN
  // Clearing sweep right after reset release: readies low, WE=1, A=0..DEPTH-1
  task automatic init_sweep();
    set0(1'b1, 1'b0, '0, '0);
    set1(1'b1, 1'b0, '0, '0);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      check("init_ready0", req0_ready, 1'b0);
      check("init_ready1", req1_ready, 1'b0);
      check("init_we", WE, 1'b1);
      check("init_a",  A,  i[AW-1:0]);
      check("init_wd", WD, '0);
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    set0(1'b0, 1'b0, '0, '0);
    set1(1'b0, 1'b0, '0, '0);
  endtask
`endif

  task automatic check_reset_outputs();
    check("rst_ready0", req0_ready, 1'b0);
    check("rst_ready1", req1_ready, 1'b0);
    check("rst_rsp0_valid", rsp0_valid, 1'b0);
    check("rst_rsp1_valid", rsp1_valid, 1'b0);
    check("rst_rsp0_rdata", rsp0_rdata, '0);
    check("rst_rsp1_rdata", rsp1_rdata, '0);
`ifdef RAM_ARB_INIT_EN
    check("rst_we", WE, 1'b1);
`else
    check("rst_we", WE, 1'b0);
`endif
    check("rst_a",  A,  '0);
    check("rst_wd", WD, '0);
  endtask

  initial begin
    rst = 1'b1;
    set0(1'b1, 1'b1, 3'd6, 32'hAAAA_5555);
    set1(1'b1, 1'b1, 3'd7, 32'h5555_AAAA);
    m_ptr = 0;
    m_rd0 = '0;
    m_rd1 = '0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

    // Reset state with both requesters pushing writes
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();

`ifdef RAM_ARB_INIT_EN
    rst = 1'b0;
    init_sweep();
    for (int i = 0; i < DEPTH; i++) begin
      set0(1'b1, 1'b0, i[AW-1:0], '0);
      cycle();
      check("init_zero", rsp0_rdata, '0);
    end
    set0(1'b0, 1'b0, '0, '0);
`else
    set0(1'b0, 1'b0, '0, '0);
    set1(1'b0, 1'b0, '0, '0);
    rst = 1'b0;
`endif

    // Fill the array with known random contents
    for (int i = 0; i < DEPTH; i++) begin
      set0(1'b1, 1'b1, i[AW-1:0], $urandom);
      cycle();
    end
    set0(1'b0, 1'b0, '0, '0);

    // Write then read from requester 0
    set0(1'b1, 1'b1, 3'd3, 32'hDEAD_BEEF);
    cycle();
    set0(1'b1, 1'b0, 3'd3, '0);
    cycle();
    check("wtr_valid", rsp0_valid, 1'b1);
    check("wtr_data", rsp0_rdata, 32'hDEAD_BEEF);
    check("wtr_rsp1", rsp1_valid, 1'b0);
    set0(1'b0, 1'b0, '0, '0);

    // Lone requester 1: four back-to-back writes
    for (int i = 0; i < 4; i++) begin
      set1(1'b1, 1'b1, $urandom_range(0, DEPTH - 1), $urandom);
      cycle();
      check("lone_ready1", req1_ready, 1'b1);
    end
    set1(1'b0, 1'b0, '0, '0);

    // Contention: pointer is back on requester 0, grants must alternate
    set0(1'b1, 1'b0, 3'd1, '0);
    set1(1'b1, 1'b0, 3'd2, '0);
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("cont_rsp0", rsp0_valid, (i % 2 == 0));
      check("cont_rsp1", rsp1_valid, (i % 2 == 1));
    end
    set0(1'b0, 1'b0, '0, '0);
    set1(1'b0, 1'b0, '0, '0);

    // Same-address ordering with pointer on requester 0
    set1(1'b1, 1'b1, 3'd5, 32'h11);
    cycle();
    set0(1'b1, 1'b0, 3'd5, '0);
    set1(1'b1, 1'b1, 3'd5, 32'h22);
    cycle();
    check("same_old", rsp0_rdata, 32'h11);
    set0(1'b0, 1'b0, '0, '0);
    cycle();
    set1(1'b0, 1'b0, '0, '0);
    set0(1'b1, 1'b0, 3'd5, '0);
    cycle();
    check("same_new", rsp0_rdata, 32'h22);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      set0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), $urandom);
      set1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), $urandom);
      cycle();
    end

    // Reset asserted while a requester-1 response is being presented
    set0(1'b0, 1'b0, '0, '0);
    set1(1'b1, 1'b0, 3'd2, '0);
    cycle();
    check("mid_rsp1_before", rsp1_valid, 1'b1);
    set0(1'b1, 1'b0, '0, '0);
    set1(1'b1, 1'b0, '0, '0);
    #1 rst = 1'b1;
    #1;
    check_reset_outputs();
    m_ptr = 0;
    m_rd0 = '0;
    m_rd1 = '0;
    @(posedge clk);
    #1;
`ifdef RAM_ARB_INIT_EN
    rst = 1'b0;
    init_sweep();
`else
    set0(1'b0, 1'b0, '0, '0);
    set1(1'b0, 1'b0, '0, '0);
    rst = 1'b0;
`endif

    // Pointer restarted on requester 0
    set0(1'b1, 1'b0, 3'd1, '0);
    set1(1'b1, 1'b0, 3'd2, '0);
    cycle();
    check("post_rst_gnt0", rsp0_valid, 1'b1);
    cycle();
    check("post_rst_gnt1", rsp1_valid, 1'b1);
    set0(1'b0, 1'b0, '0, '0);
    set1(1'b0, 1'b0, '0, '0);
    cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
